// File: rtl/mem_access_sequencer.sv
// Stalls the core around a single data-memory access: turns the controller's level
// load/store strobes into one req/ack transaction and returns load data with a valid pulse.
module mem_access_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              STM,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] wDataIn,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic              stall,
    output logic [DATA_W-1:0] loadData,
    output logic              loadValid,
    output logic              timeoutErr,
    output logic              collisionErr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;
    logic   [CNT_W-1:0] counter;
    logic               request;
    logic               lastCycle;

    assign request   = memRead | STM;
    assign lastCycle = (counter == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (request) nextState = ACCESS;
            ACCESS:  if (memAck || lastCycle) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Stall is combinational in IDLE so the PC cannot step past the memory instruction.
    always_comb begin
        memReq = 1'b0;
        stall  = 1'b0;
        case (state)
            IDLE:    stall = request;
            ACCESS: begin
                memReq = 1'b1;
                stall  = 1'b1;
            end
            default: begin
                memReq = 1'b0;
                stall  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            memWe        <= 1'b0;
            memAddr      <= '0;
            memWData     <= '0;
            loadData     <= '0;
            loadValid    <= 1'b0;
            timeoutErr   <= 1'b0;
            collisionErr <= 1'b0;
            counter      <= '0;
        end else begin
            loadValid    <= 1'b0;
            timeoutErr   <= 1'b0;
            collisionErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        memAddr      <= addrIn;
                        memWData     <= wDataIn;
                        memWe        <= STM & ~memRead;
                        counter      <= '0;
                        collisionErr <= memRead & STM;
                    end
                end
                ACCESS: begin
                    // An ack on the final allowed cycle wins over the timeout.
                    if (memAck) begin
                        if (!memWe) begin
                            loadData <= memRData;
                        end
                        loadValid <= ~memWe;
                    end else if (lastCycle) begin
                        timeoutErr <= 1'b1;
                        loadData   <= '0;
                        loadValid  <= ~memWe;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
